// File: rtl/idct_2d.sv
// 8x8 inverse DCT, separable row-column form: 8 row passes into a saturating
// intermediate buffer, then 8 column passes producing level-shifted 8-bit pixels.
module idct_2d #(
  parameter int COEF_W    = 12,
  parameter int FRAC_BITS = 12,
  parameter int MID_W     = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     idct_enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] coef [0:63],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               pix [0:63]
);

  localparam int ACC_W = MID_W + FRAC_BITS + 5;
  localparam logic signed [ACC_W-1:0] MID_MAX = ACC_W'((2 ** (MID_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MID_MIN = -MID_MAX - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(2 ** (FRAC_BITS - 1));

  typedef enum logic [1:0] {IDLE, ROW, COL, OUT} state_t;

  state_t                  state, next_state;
  logic [2:0]              idx;
  logic                    accept;
  logic signed [COEF_W-1:0] coef_buf [0:63];
  logic signed [MID_W-1:0] rowbuf  [0:7][0:7];
  logic signed [MID_W-1:0] vec_in  [0:7];
  logic signed [ACC_W-1:0] shifted [0:7];
  logic signed [MID_W-1:0] row_sat [0:7];
  logic [7:0]              col_pix [0:7];

  // Cosine table C[n][k] scaled by 2^12, folded onto the first-quadrant magnitudes.
  function automatic int cos_tab(input int n, input int k);
    int m;
    int f;
    int mag;
    if (k == 0) return 1448;
    m = ((2 * n + 1) * k) % 32;
    if (m > 16) m = 32 - m;
    f = (m > 8) ? 16 - m : m;
    case (f)
      0:       mag = 2048;
      1:       mag = 2009;
      2:       mag = 1892;
      3:       mag = 1703;
      4:       mag = 1448;
      5:       mag = 1138;
      6:       mag = 784;
      7:       mag = 400;
      default: mag = 0;
    endcase
    return (m > 8) ? -mag : mag;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = idct_enable ? ROW : OUT;
      end
      ROW: if (idx == 3'd7) next_state = COL;
      COL: if (idx == 3'd7) next_state = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && in_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                         idx <= 3'd0;
    else if (accept)                      idx <= 3'd0;
    else if (state == ROW || state == COL) idx <= idx + 3'd1;
  end

  // The single 1D engine reads a coefficient row during ROW and a rowbuf column during COL.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      if (state == COL) vec_in[k] = rowbuf[k][idx];
      else              vec_in[k] = MID_W'(coef_buf[{idx, 3'(k)}]);
    end
  end

  always_comb begin
    logic signed [ACC_W-1:0] acc;
    acc = '0;
    for (int n = 0; n < 8; n++) begin
      acc = HALF;
      for (int k = 0; k < 8; k++)
        acc += ACC_W'(vec_in[k]) * ACC_W'(cos_tab(n, k));
      shifted[n] = acc >>> FRAC_BITS;
    end
  end

  always_comb begin
    logic signed [ACC_W-1:0] biased;
    biased = '0;
    for (int n = 0; n < 8; n++) begin
      if (shifted[n] > MID_MAX)      row_sat[n] = MID_W'(MID_MAX);
      else if (shifted[n] < MID_MIN) row_sat[n] = MID_W'(MID_MIN);
      else                           row_sat[n] = MID_W'(shifted[n]);
      biased = shifted[n] + ACC_W'(128);
      if (biased < 0)                    col_pix[n] = 8'd0;
      else if (biased > ACC_W'(255))     col_pix[n] = 8'd255;
      else                               col_pix[n] = 8'(biased);
    end
  end

  // Working buffers carry no reset; they are always rewritten before being read.
  always_ff @(posedge clock) begin
    if (accept)
      for (int k = 0; k < 64; k++) coef_buf[k] <= coef[k];
    if (state == ROW)
      for (int v = 0; v < 8; v++)
        if (3'(v) == idx)
          for (int n = 0; n < 8; n++) rowbuf[v][n] <= row_sat[n];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 64; k++) pix[k] <= 8'd0;
    end else if (accept && !idct_enable) begin
      for (int k = 0; k < 64; k++) pix[k] <= coef[k][7:0];
    end else if (state == COL) begin
      for (int k = 0; k < 64; k++)
        if (3'(k % 8) == idx) pix[k] <= col_pix[k / 8];
    end
  end

endmodule
